// File: rtl/queue_pkg.sv
// Shared types and defaults for the queue-call display controller.
package queue_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam int DEF_NUM_W  = 8;
  localparam int DEF_BLINKS = 3;

endpackage

// File: rtl/call_blink_ctrl.sv
// Announces a called queue number by blinking the display BLINKS times, paced by an external phase timer.
// Optional macro CALL_BLINK_PENDING_EN keeps one call that arrives mid-announcement and plays it next.
module call_blink_ctrl
  import queue_pkg::*;
#(
  parameter int BLINKS = DEF_BLINKS,
  parameter int NUM_W  = DEF_NUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             call,
  input  logic [NUM_W-1:0] call_num,
  output logic             tmr_start,
  input  logic             tmr_last,
  output logic [NUM_W-1:0] disp_num,
  output logic             disp_on,
  output logic             busy
);

  localparam int              CNT_W    = $clog2(BLINKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINKS - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   blink_cnt, blink_cnt_n;
  logic               shown, shown_n;
  logic [NUM_W-1:0]   disp_num_n;
  logic               tmr_start_n, disp_on_n, busy_n;

`ifdef CALL_BLINK_PENDING_EN
  logic               pend_vld, pend_vld_n;
  logic [NUM_W-1:0]   pend_num, pend_num_n;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
    state_n     = state;
    blink_cnt_n = blink_cnt;
    shown_n     = shown;
    disp_num_n  = disp_num;
    tmr_start_n = 1'b0;
`ifdef CALL_BLINK_PENDING_EN
    pend_vld_n  = pend_vld;
    pend_num_n  = pend_num;
    if (state != IDLE && call) begin
      pend_vld_n = 1'b1;
      pend_num_n = call_num;
    end
`endif

    unique case (state)
      IDLE: begin
        if (call) begin
          state_n     = ON;
          disp_num_n  = call_num;
          blink_cnt_n = '0;
          shown_n     = 1'b1;
          tmr_start_n = 1'b1;
        end
      end
      ON: begin
        if (tmr_last) begin
          state_n     = OFF;
          tmr_start_n = 1'b1;
        end
      end
      OFF: begin
        if (tmr_last) begin
          if (blink_cnt != CNT_LAST) begin
            state_n     = ON;
            blink_cnt_n = blink_cnt + 1'b1;
            tmr_start_n = 1'b1;
          end else begin
            state_n = IDLE;
`ifdef CALL_BLINK_PENDING_EN
            // A call landing on the final tmr_last cycle is taken directly, same as a stored one.
            if (call || pend_vld) begin
              state_n     = ON;
              disp_num_n  = call ? call_num : pend_num;
              blink_cnt_n = '0;
              pend_vld_n  = 1'b0;
              tmr_start_n = 1'b1;
            end
`endif
          end
        end
      end
      default: state_n = IDLE;
    endcase

    disp_on_n = (state_n == ON) || (state_n == IDLE && shown_n);
    busy_n    = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      blink_cnt <= '0;
      shown     <= 1'b0;
      disp_num  <= '0;
      disp_on   <= 1'b0;
      busy      <= 1'b0;
      tmr_start <= 1'b0;
`ifdef CALL_BLINK_PENDING_EN
      pend_vld  <= 1'b0;
      pend_num  <= '0;
`endif
    end else begin
      state     <= state_n;
      blink_cnt <= blink_cnt_n;
      shown     <= shown_n;
      disp_num  <= disp_num_n;
      disp_on   <= disp_on_n;
      busy      <= busy_n;
      tmr_start <= tmr_start_n;
`ifdef CALL_BLINK_PENDING_EN
      pend_vld  <= pend_vld_n;
      pend_num  <= pend_num_n;
`endif
    end
  end

endmodule
